// File: rtl/freq_meas_pkg.sv
// Shared types and defaults for the frequency-measurement statistics path.
package freq_meas_pkg;

  typedef enum logic [1:0] {
    FLUSH,
    ACCUM,
    HOLD
  } state_t;

  localparam int DEFAULT_COUNTER_BITS = 32;
  localparam int DEFAULT_LOG2_SAMPLES = 3;
  localparam int DEFAULT_WINDOW       = 1 << DEFAULT_LOG2_SAMPLES;

  function automatic int window_size(input int log2_samples);
    return 1 << log2_samples;
  endfunction

endpackage

// File: rtl/freq_stats_accumulator_if.sv
// Measurement input bus and result handshake between the frequency counter,
// the statistics accumulator and the readout logic.
interface freq_stats_accumulator_if #(
  parameter int COUNTER_BITS = freq_meas_pkg::DEFAULT_COUNTER_BITS
);

  logic [COUNTER_BITS-1:0] TIME_HIGH;
  logic [COUNTER_BITS-1:0] TIME_LOW;
  logic [COUNTER_BITS-1:0] PERIOD;
  logic                    PULSE;

  logic [COUNTER_BITS-1:0] AVG_PERIOD;
  logic [COUNTER_BITS-1:0] AVG_HIGH;
  logic [COUNTER_BITS-1:0] MIN_PERIOD;
  logic [COUNTER_BITS-1:0] MAX_PERIOD;
  logic                    VALID;
  logic                    READY;

  modport master (
    output TIME_HIGH, TIME_LOW, PERIOD, PULSE, READY,
    input  AVG_PERIOD, AVG_HIGH, MIN_PERIOD, MAX_PERIOD, VALID
  );

  modport slave (
    input  TIME_HIGH, TIME_LOW, PERIOD, PULSE, READY,
    output AVG_PERIOD, AVG_HIGH, MIN_PERIOD, MAX_PERIOD, VALID
  );

endinterface

// File: rtl/freq_minmax_tracker.sv
// Running minimum/maximum of a sample stream; the *_next outputs already
// include the sample presented this cycle so a window can close on it.
module freq_minmax_tracker #(
  parameter int WIDTH = freq_meas_pkg::DEFAULT_COUNTER_BITS
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clear,
  input  logic             sample,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] min_next,
  output logic [WIDTH-1:0] max_next
);

  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_base;
  logic [WIDTH-1:0] max_base;

  // A clear in the same cycle as a sample makes that sample the first of a new window.
  always_comb begin
    min_base = clear ? '1 : min_q;
    max_base = clear ? '0 : max_q;
    min_next = min_base;
    max_next = max_base;
    if (sample && (value < min_base)) min_next = value;
    if (sample && (value > max_base)) max_next = value;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_next;
      max_q <= max_next;
    end
  end

endmodule

// File: rtl/freq_stats_accumulator.sv
// Windowed period/high-time statistics over the frequency counter output,
// with start-up discard, result handshake, overrun and stall flags.
module freq_stats_accumulator
  import freq_meas_pkg::*;
#(
  parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS,
  parameter int LOG2_SAMPLES = DEFAULT_LOG2_SAMPLES,
  parameter int DISCARD      = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     EN,
  freq_stats_accumulator_if.slave  bus,
  output logic                     OVERRUN,
  output logic                     STALE
);

  localparam int WINDOW   = window_size(LOG2_SAMPLES);
  localparam int SUM_BITS = COUNTER_BITS + LOG2_SAMPLES;
  localparam int CNT_BITS = LOG2_SAMPLES + 1;
  localparam logic [CNT_BITS-1:0]   WINDOW_LAST  = CNT_BITS'(WINDOW - 1);
  localparam logic [3:0]            DISCARD_LAST = 4'(DISCARD - 1);
  localparam logic [TIMEOUT_BITS:0] IDLE_LIMIT   = {1'b1, {TIMEOUT_BITS{1'b0}}};

  state_t                  state;
  state_t                  next_state;
  logic [3:0]              flush_cnt;
  logic [CNT_BITS-1:0]     sample_cnt;
  logic [SUM_BITS-1:0]     sum_period;
  logic [SUM_BITS-1:0]     sum_high;
  logic [TIMEOUT_BITS:0]   idle_cnt;

  logic                    handshake;
  logic                    take_sample;
  logic                    flush_done;
  logic                    window_done;
  logic [CNT_BITS-1:0]     cnt_base;
  logic [CNT_BITS-1:0]     cnt_next;
  logic [SUM_BITS-1:0]     sum_period_next;
  logic [SUM_BITS-1:0]     sum_high_next;
  logic [COUNTER_BITS-1:0] min_next;
  logic [COUNTER_BITS-1:0] max_next;
  logic                    unused_time_low;

  assign unused_time_low = ^bus.TIME_LOW;

  // The handshake cycle restarts the window, so its PULSE becomes sample 1.
  assign handshake   = EN && (state == HOLD) && bus.VALID && bus.READY;
  assign take_sample = EN && bus.PULSE && ((state == ACCUM) || handshake);
  assign flush_done  = (DISCARD == 0) || (bus.PULSE && (flush_cnt == DISCARD_LAST));
  assign cnt_base    = handshake ? '0 : sample_cnt;
  assign cnt_next    = cnt_base + (take_sample ? CNT_BITS'(1) : '0);
  assign window_done = take_sample && (cnt_base == WINDOW_LAST);

  assign sum_period_next = (handshake ? '0 : sum_period)
                         + (take_sample ? SUM_BITS'(bus.PERIOD) : '0);
  assign sum_high_next   = (handshake ? '0 : sum_high)
                         + (take_sample ? SUM_BITS'(bus.TIME_HIGH) : '0);

  freq_minmax_tracker #(
    .WIDTH (COUNTER_BITS)
  ) u_minmax (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clear    (!EN || handshake),
    .sample   (take_sample),
    .value    (bus.PERIOD),
    .min_next (min_next),
    .max_next (max_next)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= FLUSH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!EN) begin
      next_state = FLUSH;
    end else begin
      case (state)
        FLUSH:   if (flush_done)  next_state = ACCUM;
        ACCUM:   if (window_done) next_state = HOLD;
        HOLD:    if (handshake)   next_state = window_done ? HOLD : ACCUM;
        default: next_state = FLUSH;
      endcase
    end
  end

  // Result data registers deliberately survive EN low; only reset clears them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flush_cnt      <= '0;
      sample_cnt     <= '0;
      sum_period     <= '0;
      sum_high       <= '0;
      bus.VALID      <= 1'b0;
      bus.AVG_PERIOD <= '0;
      bus.AVG_HIGH   <= '0;
      bus.MIN_PERIOD <= '0;
      bus.MAX_PERIOD <= '0;
      OVERRUN        <= 1'b0;
    end else if (!EN) begin
      flush_cnt  <= '0;
      sample_cnt <= '0;
      sum_period <= '0;
      sum_high   <= '0;
      bus.VALID  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (state == FLUSH) begin
        if (flush_done)     flush_cnt <= '0;
        else if (bus.PULSE) flush_cnt <= flush_cnt + 4'd1;
      end
      if (take_sample || handshake) begin
        sample_cnt <= cnt_next;
        sum_period <= sum_period_next;
        sum_high   <= sum_high_next;
      end
      if (window_done) begin
        bus.VALID      <= 1'b1;
        bus.AVG_PERIOD <= sum_period_next[LOG2_SAMPLES +: COUNTER_BITS];
        bus.AVG_HIGH   <= sum_high_next[LOG2_SAMPLES +: COUNTER_BITS];
        bus.MIN_PERIOD <= min_next;
        bus.MAX_PERIOD <= max_next;
      end else if (handshake) begin
        bus.VALID <= 1'b0;
      end
      if ((state == HOLD) && bus.PULSE && !bus.READY) OVERRUN <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                      idle_cnt <= '0;
    else if (!EN || bus.PULSE)       idle_cnt <= '0;
    else if (idle_cnt != IDLE_LIMIT) idle_cnt <= idle_cnt + 1'b1;
  end

  assign STALE = (idle_cnt == IDLE_LIMIT);

endmodule

// File: tb/tb_freq_stats_accumulator.sv
// Directed self-checking bench for freq_stats_accumulator (16-bit, 4-sample
// window, 2 discards, 16-cycle stall timeout).
module tb_freq_stats_accumulator;
  import freq_meas_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  logic EN;
  logic OVERRUN;
  logic STALE;

  int tests_run    = 0;
  int tests_failed = 0;

  freq_stats_accumulator_if #(.COUNTER_BITS(16)) bus ();

  freq_stats_accumulator #(
    .COUNTER_BITS (16),
    .LOG2_SAMPLES (2),
    .DISCARD      (2),
    .TIMEOUT_BITS (4)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .bus     (bus),
    .OVERRUN (OVERRUN),
    .STALE   (STALE)
  );

  always #5 CLK = ~CLK;

  // Presents one PULSE for a single clock and returns 1 time unit after that edge.
  task automatic drive_pulse(input logic [15:0] period, input logic [15:0] high);
    bus.PULSE     = 1'b1;
    bus.PERIOD    = period;
    bus.TIME_HIGH = high;
    bus.TIME_LOW  = period - high;
    @(posedge CLK); #1;
    bus.PULSE = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; EN = 1'b1;
    bus.PULSE = 1'b0; bus.READY = 1'b0;
    bus.PERIOD = '0; bus.TIME_HIGH = '0; bus.TIME_LOW = '0;
    repeat (3) @(posedge CLK);
    #1;
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %0d expected 0", bus.VALID); end
    tests_run++; if (bus.AVG_PERIOD !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_avg_period: got %0d expected 0", bus.AVG_PERIOD); end
    tests_run++; if (bus.MIN_PERIOD !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_min: got %0d expected 0", bus.MIN_PERIOD); end
    tests_run++; if (OVERRUN !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %0d expected 0", OVERRUN); end
    tests_run++; if (STALE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stale: got %0d expected 0", STALE); end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    drive_pulse(16'd999, 16'd500);
    tests_run++; if (dut.state !== FLUSH) begin tests_failed++; $display("[TB] FAIL flush_after_1: got %0d expected %0d", dut.state, FLUSH); end
    drive_pulse(16'd999, 16'd500);
    tests_run++; if (dut.state !== ACCUM) begin tests_failed++; $display("[TB] FAIL flush_to_accum: got %0d expected %0d", dut.state, ACCUM); end
    tests_run++; if (dut.sample_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL flush_no_sample: got %0d expected 0", dut.sample_cnt); end
  endtask

  task automatic test_nominal_window;
    drive_pulse(16'd100, 16'd50);
    drive_pulse(16'd104, 16'd52);
    drive_pulse(16'd96,  16'd48);
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL nominal_early_valid: got %0d expected 0", bus.VALID); end
    drive_pulse(16'd102, 16'd51);
    tests_run++; if (bus.VALID !== 1'b1) begin tests_failed++; $display("[TB] FAIL nominal_valid: got %0d expected 1", bus.VALID); end
    tests_run++; if (bus.AVG_PERIOD !== 16'd100) begin tests_failed++; $display("[TB] FAIL nominal_avg_period: got %0d expected 100", bus.AVG_PERIOD); end
    tests_run++; if (bus.AVG_HIGH !== 16'd50) begin tests_failed++; $display("[TB] FAIL nominal_avg_high: got %0d expected 50", bus.AVG_HIGH); end
    tests_run++; if (bus.MIN_PERIOD !== 16'd96) begin tests_failed++; $display("[TB] FAIL nominal_min: got %0d expected 96", bus.MIN_PERIOD); end
    tests_run++; if (bus.MAX_PERIOD !== 16'd104) begin tests_failed++; $display("[TB] FAIL nominal_max: got %0d expected 104", bus.MAX_PERIOD); end
    tests_run++; if (OVERRUN !== 1'b0) begin tests_failed++; $display("[TB] FAIL nominal_overrun: got %0d expected 0", OVERRUN); end
  endtask

  task automatic test_backpressure;
    drive_pulse(16'd300, 16'd10);
    drive_pulse(16'd10,  16'd5);
    drive_pulse(16'd500, 16'd400);
    tests_run++; if (bus.VALID !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_valid_held: got %0d expected 1", bus.VALID); end
    tests_run++; if (bus.AVG_PERIOD !== 16'd100) begin tests_failed++; $display("[TB] FAIL bp_avg_stable: got %0d expected 100", bus.AVG_PERIOD); end
    tests_run++; if (bus.MIN_PERIOD !== 16'd96) begin tests_failed++; $display("[TB] FAIL bp_min_stable: got %0d expected 96", bus.MIN_PERIOD); end
    tests_run++; if (bus.MAX_PERIOD !== 16'd104) begin tests_failed++; $display("[TB] FAIL bp_max_stable: got %0d expected 104", bus.MAX_PERIOD); end
    tests_run++; if (OVERRUN !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_overrun: got %0d expected 1", OVERRUN); end
    bus.READY = 1'b1;
    drive_pulse(16'd200, 16'd80);
    bus.READY = 1'b0;
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_valid_fall: got %0d expected 0", bus.VALID); end
    drive_pulse(16'd200, 16'd80);
    drive_pulse(16'd200, 16'd80);
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_early_valid: got %0d expected 0", bus.VALID); end
    drive_pulse(16'd200, 16'd80);
    tests_run++; if (bus.VALID !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp2_valid: got %0d expected 1", bus.VALID); end
    tests_run++; if (bus.AVG_PERIOD !== 16'd200) begin tests_failed++; $display("[TB] FAIL bp2_avg_period: got %0d expected 200", bus.AVG_PERIOD); end
    tests_run++; if (bus.AVG_HIGH !== 16'd80) begin tests_failed++; $display("[TB] FAIL bp2_avg_high: got %0d expected 80", bus.AVG_HIGH); end
    tests_run++; if (bus.MIN_PERIOD !== 16'd200) begin tests_failed++; $display("[TB] FAIL bp2_min: got %0d expected 200", bus.MIN_PERIOD); end
    tests_run++; if (bus.MAX_PERIOD !== 16'd200) begin tests_failed++; $display("[TB] FAIL bp2_max: got %0d expected 200", bus.MAX_PERIOD); end
    tests_run++; if (OVERRUN !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp2_overrun_sticky: got %0d expected 1", OVERRUN); end
  endtask

  task automatic test_en_drop;
    EN = 1'b0;
    @(posedge CLK); #1;
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_valid: got %0d expected 0", bus.VALID); end
    tests_run++; if (OVERRUN !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_overrun: got %0d expected 0", OVERRUN); end
    tests_run++; if (bus.AVG_PERIOD !== 16'd200) begin tests_failed++; $display("[TB] FAIL en_data_kept: got %0d expected 200", bus.AVG_PERIOD); end
    EN = 1'b1;
    drive_pulse(16'd7, 16'd3);
    drive_pulse(16'd7, 16'd3);
    drive_pulse(16'd40, 16'd20);
    drive_pulse(16'd44, 16'd22);
    drive_pulse(16'd48, 16'd24);
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_early_valid: got %0d expected 0", bus.VALID); end
    drive_pulse(16'd52, 16'd26);
    tests_run++; if (bus.VALID !== 1'b1) begin tests_failed++; $display("[TB] FAIL en_valid_after: got %0d expected 1", bus.VALID); end
    tests_run++; if (bus.AVG_PERIOD !== 16'd46) begin tests_failed++; $display("[TB] FAIL en_avg_period: got %0d expected 46", bus.AVG_PERIOD); end
    tests_run++; if (bus.AVG_HIGH !== 16'd23) begin tests_failed++; $display("[TB] FAIL en_avg_high: got %0d expected 23", bus.AVG_HIGH); end
    tests_run++; if (bus.MIN_PERIOD !== 16'd40) begin tests_failed++; $display("[TB] FAIL en_min: got %0d expected 40", bus.MIN_PERIOD); end
    tests_run++; if (bus.MAX_PERIOD !== 16'd52) begin tests_failed++; $display("[TB] FAIL en_max: got %0d expected 52", bus.MAX_PERIOD); end
    bus.READY = 1'b1;
    @(posedge CLK); #1;
    bus.READY = 1'b0;
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_handshake: got %0d expected 0", bus.VALID); end
  endtask

  task automatic test_stale;
    drive_pulse(16'd10, 16'd5);
    repeat (15) @(posedge CLK);
    #1;
    tests_run++; if (STALE !== 1'b0) begin tests_failed++; $display("[TB] FAIL stale_early: got %0d expected 0", STALE); end
    @(posedge CLK); #1;
    tests_run++; if (STALE !== 1'b1) begin tests_failed++; $display("[TB] FAIL stale_set: got %0d expected 1", STALE); end
    drive_pulse(16'd10, 16'd5);
    tests_run++; if (STALE !== 1'b0) begin tests_failed++; $display("[TB] FAIL stale_clear: got %0d expected 0", STALE); end
  endtask

  task automatic test_async_reset;
    #3;
    RST_N = 1'b0;
    #1;
    tests_run++; if (bus.AVG_PERIOD !== 16'd0) begin tests_failed++; $display("[TB] FAIL areset_avg_period: got %0d expected 0", bus.AVG_PERIOD); end
    tests_run++; if (bus.AVG_HIGH !== 16'd0) begin tests_failed++; $display("[TB] FAIL areset_avg_high: got %0d expected 0", bus.AVG_HIGH); end
    tests_run++; if (bus.MAX_PERIOD !== 16'd0) begin tests_failed++; $display("[TB] FAIL areset_max: got %0d expected 0", bus.MAX_PERIOD); end
    tests_run++; if (dut.state !== FLUSH) begin tests_failed++; $display("[TB] FAIL areset_state: got %0d expected %0d", dut.state, FLUSH); end
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    drive_pulse(16'd999, 16'd900);
    drive_pulse(16'd999, 16'd900);
    drive_pulse(16'd8, 16'd4);
    drive_pulse(16'd8, 16'd4);
    drive_pulse(16'd8, 16'd4);
    tests_run++; if (bus.VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_early_valid: got %0d expected 0", bus.VALID); end
    drive_pulse(16'd8, 16'd4);
    tests_run++; if (bus.VALID !== 1'b1) begin tests_failed++; $display("[TB] FAIL areset_valid: got %0d expected 1", bus.VALID); end
    tests_run++; if (bus.AVG_PERIOD !== 16'd8) begin tests_failed++; $display("[TB] FAIL areset_avg: got %0d expected 8", bus.AVG_PERIOD); end
    tests_run++; if (bus.AVG_HIGH !== 16'd4) begin tests_failed++; $display("[TB] FAIL areset_high: got %0d expected 4", bus.AVG_HIGH); end
    tests_run++; if (bus.MIN_PERIOD !== 16'd8) begin tests_failed++; $display("[TB] FAIL areset_min_tie: got %0d expected 8", bus.MIN_PERIOD); end
    tests_run++; if (bus.MAX_PERIOD !== 16'd8) begin tests_failed++; $display("[TB] FAIL areset_max_tie: got %0d expected 8", bus.MAX_PERIOD); end
  endtask

  initial begin
    test_reset;
    test_nominal_window;
    test_backpressure;
    test_en_drop;
    test_stale;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/freq_stats_accumulator.md
Name: freq_stats_accumulator

Overview:
- Downstream consumer of the frequency counter's per-period measurements (TIME_HIGH, TIME_LOW, PERIOD, PULSE).
- Discards start-up measurements, then accumulates a window of 2^LOG2_SAMPLES periods and reports the results through a VALID/READY handshake to the readout logic:
  - average period
  - average high time
  - minimum period
  - maximum period
- Also flags dropped samples and loss of input activity.

Parameters:
- COUNTER_BITS, 32: width of the incoming measurement words and of every reported statistic.
- LOG2_SAMPLES, 3: log2 of the number of periods per window (window = 8 samples by default); legal range 0..8.
- DISCARD, 2: number of initial PULSE events ignored after reset or enable; legal range 0..15.
- TIMEOUT_BITS, 20: a stall is flagged after 2^TIMEOUT_BITS clock cycles without a PULSE.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- EN  in  1  enable; low forces state FLUSH and clears the window.
- TIME_HIGH  in  COUNTER_BITS  high time of the last period, in clock cycles.
- TIME_LOW  in  COUNTER_BITS  low time; observed for interface completeness, not used in the statistics.
- PERIOD  in  COUNTER_BITS  period measurement, in clock cycles.
- PULSE  in  1  single-cycle strobe; TIME_HIGH and PERIOD are sampled in this cycle.
- AVG_PERIOD  out  COUNTER_BITS  sum of PERIOD >> LOG2_SAMPLES (truncating).
- AVG_HIGH  out  COUNTER_BITS  sum of TIME_HIGH >> LOG2_SAMPLES.
- MIN_PERIOD  out  COUNTER_BITS  smallest PERIOD in the window.
- MAX_PERIOD  out  COUNTER_BITS  largest PERIOD in the window.
- VALID  out  1  result registers hold a complete window.
- READY  in  1  consumer accepts the result when VALID && READY.
- OVERRUN  out  1  sticky; a PULSE was dropped while a result was held.
- STALE  out  1  no PULSE for 2^TIMEOUT_BITS cycles.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = FLUSH.
  - All outputs 0; all accumulators, counters and min/max registers cleared.
- Accumulator widths:
  - Sums are COUNTER_BITS+LOG2_SAMPLES wide, so they never overflow.
  - Min register initialises to all-ones; max register initialises to 0.
- FLUSH state:
  - Counts PULSEs and ignores the data.
  - After DISCARD pulses, goes to ACCUM. If DISCARD=0, goes to ACCUM on the next cycle.
- ACCUM state:
  - On each PULSE: add PERIOD and TIME_HIGH to the sums, update min and max, increment the sample count.
  - On the pulse that completes the window (count reaches 2^LOG2_SAMPLES):
    - Next edge loads the output registers from the final values, including that last sample.
    - VALID rises one cycle after that final PULSE; state = HOLD.
- HOLD state:
  - Outputs are stable while VALID is high and READY is low.
  - On VALID && READY: VALID falls next cycle; accumulators are cleared; state = ACCUM (no re-flush).
  - A PULSE in the same cycle as the handshake is taken as sample 1 of the new window.
  - A PULSE while VALID is high and READY is low is dropped and sets OVERRUN.
- OVERRUN clearing:
  - Cleared only by reset or by EN low.
  - Handshakes do not clear it.
- EN low (any state, including mid-HOLD):
  - Next edge: state = FLUSH, VALID = 0, accumulators and counters cleared.
  - Output data registers retain their last values.
- STALE:
  - An idle counter increments every cycle while EN is high and saturates at 2^TIMEOUT_BITS.
  - STALE = 1 while the counter is saturated.
  - The counter resets on PULSE or EN low; STALE falls on the cycle after the PULSE.
- Ties: PERIOD equal to the current min or max leaves that register unchanged in value (no observable difference).
- Latency: 1 cycle from the final PULSE of a window to VALID.

Decomposition:
- Shared package (freq_meas_pkg):
  - state enum {FLUSH, ACCUM, HOLD}.
  - Default COUNTER_BITS.
  - Localparam WINDOW = 1 << LOG2_SAMPLES.
- One natural sub-module: freq_minmax_tracker.
  - Holds the min and max registers.
  - Inputs: clear, sample strobe, sample value.
- FSM, accumulators, handshake and timeout logic stay in the top level.

Test Plan:
- Reset and flush:
  - Config: COUNTER_BITS=16, LOG2_SAMPLES=2, DISCARD=2.
  - Stimulus: RST_N low; then 2 PULSEs with PERIOD=999.
  - Required: all outputs 0 after reset; no sample accumulated; state enters ACCUM.
- Nominal window:
  - Stimulus: 4 PULSEs with PERIOD = 100, 104, 96, 102 and TIME_HIGH = 50, 52, 48, 51.
  - Required: VALID 1 cycle after the 4th PULSE; AVG_PERIOD=100 (402>>2); AVG_HIGH=50 (201>>2); MIN_PERIOD=96; MAX_PERIOD=104.
- Backpressure:
  - Stimulus: hold READY low and send 3 more PULSEs.
  - Required: outputs unchanged; OVERRUN=1.
  - Then assert READY together with a PULSE of PERIOD=200, followed by 3 PULSEs of PERIOD=200.
  - Required: next result AVG_PERIOD=200, MIN_PERIOD=200, MAX_PERIOD=200; OVERRUN still 1.
- EN drop mid-HOLD:
  - Stimulus: deassert EN while VALID=1.
  - Required: VALID=0 and OVERRUN=0 next cycle; re-enable then needs 2 discarded + 4 counted PULSEs before VALID.
- Stale detection:
  - Config: TIMEOUT_BITS=4.
  - Stimulus: no PULSE for 16 cycles.
  - Required: STALE=1; one PULSE gives STALE=0 on the following cycle.
- Async reset mid-ACCUM:
  - Stimulus: pulse RST_N low between clock edges after 2 samples.
  - Required: outputs are 0 immediately, without waiting for a clock edge; a full flush plus window is needed before the next VALID.
